// File: rtl/wishbone_bram_pl_if.sv
// ---------------------------------------------------------------------------
// wishbone_bram_pl_if
// Wishbone Classic Pipelined bus bundle for the wishbone_bram_pl target.
//   CYC, STB, WE      : cycle, strobe, write select         (master -> slave)
//   ADR               : word address                        (master -> slave)
//   SEL               : byte-lane selects                   (master -> slave)
//   DAT_I, TGD_I      : write data and per-byte parity      (master -> slave)
//   STALL             : back-pressure, tied low by the slave (slave -> master)
//   ACK, ERR          : beat termination                    (slave -> master)
//   DAT_O, TGD_O      : read data and stored parity         (slave -> master)
// ---------------------------------------------------------------------------
interface wishbone_bram_pl_if #(
    parameter int AddressWidth = 12,
    parameter int DataWidth    = 32
);
    logic                      CYC;
    logic                      STB;
    logic                      WE;
    logic [AddressWidth-1:0]   ADR;
    logic [DataWidth/8-1:0]    SEL;
    logic [DataWidth-1:0]      DAT_I;
    logic [DataWidth/8-1:0]    TGD_I;
    logic                      STALL;
    logic                      ACK;
    logic                      ERR;
    logic [DataWidth-1:0]      DAT_O;
    logic [DataWidth/8-1:0]    TGD_O;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_I, TGD_I,
        input  STALL, ACK, ERR, DAT_O, TGD_O
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_I, TGD_I,
        output STALL, ACK, ERR, DAT_O, TGD_O
    );
endinterface

// File: rtl/wishbone_bram_pl.sv
// ---------------------------------------------------------------------------
// wishbone_bram_pl
// Single-port RAM target on Wishbone Classic Pipelined. Accepts one beat per
// cycle (never stalls), writes with per-byte enables, stores one even-parity
// bit per byte (from TGD_I) and checks it on reads. A read with a failing
// selected lane ends in ERR instead of ACK. Both reads and writes terminate
// exactly ReadLatency cycles after acceptance, in acceptance order.
//
// Ports:
//   CLK       : rising-edge clock
//   RST_N     : asynchronous active-low reset (control and outputs only)
//   bus       : Wishbone slave modport (see wishbone_bram_pl_if)
//   ErrClear  : synchronous pulse, clears ErrCount
//   ErrCount  : saturating count of parity-failed reads
//   ErrAddr   : ADR of the most recent parity-failed read
// ---------------------------------------------------------------------------
module wishbone_bram_pl #(
    parameter int AddressWidth = 12,
    parameter int DataWidth    = 32,
    parameter int Parity       = 1,
    parameter int ReadLatency  = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    wishbone_bram_pl_if.slave       bus,
    input  logic                    ErrClear,
    output logic [7:0]              ErrCount,
    output logic [AddressWidth-1:0] ErrAddr
);

    localparam int Lanes = DataWidth / 8;
    localparam int Depth = 2 ** AddressWidth;

    if (ReadLatency < 1 || ReadLatency > 3) begin : g_bad_latency
        $error("wishbone_bram_pl: ReadLatency must be 1, 2 or 3");
    end
    if (DataWidth != 8 && DataWidth != 16 && DataWidth != 32 && DataWidth != 64) begin : g_bad_width
        $error("wishbone_bram_pl: DataWidth must be 8, 16, 32 or 64");
    end

    function automatic logic [DataWidth-1:0] lane_mask(input logic [Lanes-1:0] sel);
        logic [DataWidth-1:0] m;
        for (int i = 0; i < Lanes; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

    function automatic logic [Lanes-1:0] byte_parity(input logic [DataWidth-1:0] d);
        logic [Lanes-1:0] p;
        for (int i = 0; i < Lanes; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    logic acc;
    logic wr_acc;
    assign acc    = bus.CYC & bus.STB;
    assign wr_acc = acc & bus.WE;

    assign bus.STALL = 1'b0;

    // ---- storage: written on the acceptance edge -------------------------
    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] rd_dat;
    logic [Lanes-1:0]     rd_par;
    logic                 acc_fail;

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            for (int i = 0; i < Lanes; i++) begin
                if (bus.SEL[i]) begin
                    mem[bus.ADR][8*i +: 8] <= bus.DAT_I[8*i +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[bus.ADR];

    if (Parity != 0) begin : g_par
        logic [Lanes-1:0] par_mem [Depth];

        always_ff @(posedge CLK) begin
            if (wr_acc) begin
                for (int i = 0; i < Lanes; i++) begin
                    if (bus.SEL[i]) begin
                        par_mem[bus.ADR][i] <= bus.TGD_I[i];
                    end
                end
            end
        end

        assign rd_par = par_mem[bus.ADR];
        // Only selected lanes of a read can fail; even parity means the byte
        // XOR plus its stored bit must be zero.
        assign acc_fail = acc & ~bus.WE & |(bus.SEL & (byte_parity(rd_dat) ^ rd_par));
    end else begin : g_nopar
        logic unused_tgd;
        assign unused_tgd = ^bus.TGD_I;
        assign rd_par     = '0;
        assign acc_fail   = 1'b0;
    end

    // Values captured on the acceptance edge; unselected lanes read as zero.
    logic [DataWidth-1:0] acc_dat;
    logic [Lanes-1:0]     acc_tgd;
    assign acc_dat = rd_dat & lane_mask(bus.SEL);
    assign acc_tgd = rd_par & bus.SEL;

    // Beat presented to the output register stage.
    logic                    src_vld;
    logic                    src_we;
    logic                    src_fail;
    logic [AddressWidth-1:0] src_adr;
    logic [DataWidth-1:0]    src_dat;
    logic [Lanes-1:0]        src_tgd;

    if (ReadLatency == 1) begin : g_lat1
        assign src_vld  = acc;
        assign src_we   = bus.WE;
        assign src_fail = acc_fail;
        assign src_adr  = bus.ADR;
        assign src_dat  = acc_dat;
        assign src_tgd  = acc_tgd;
    end else begin : g_lat23
        // ---- stage p0: array sampled on the acceptance edge --------------
        logic                    vld_p0;
        logic                    we_p0;
        logic                    fail_p0;
        logic [AddressWidth-1:0] adr_p0;
        logic [DataWidth-1:0]    dat_p0;
        logic [Lanes-1:0]        tgd_p0;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                vld_p0 <= 1'b0;
            end else begin
                vld_p0 <= acc;
            end
        end

        always_ff @(posedge CLK) begin
            if (acc) begin
                we_p0   <= bus.WE;
                fail_p0 <= acc_fail;
                adr_p0  <= bus.ADR;
                dat_p0  <= acc_dat;
                tgd_p0  <= acc_tgd;
            end
        end

        if (ReadLatency == 2) begin : g_src_p0
            assign src_vld  = vld_p0;
            assign src_we   = we_p0;
            assign src_fail = fail_p0;
            assign src_adr  = adr_p0;
            assign src_dat  = dat_p0;
            assign src_tgd  = tgd_p0;
        end else begin : g_p1
            // ---- stage p1: extra delay stage -----------------------------
            logic                    vld_p1;
            logic                    we_p1;
            logic                    fail_p1;
            logic [AddressWidth-1:0] adr_p1;
            logic [DataWidth-1:0]    dat_p1;
            logic [Lanes-1:0]        tgd_p1;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_p1 <= 1'b0;
                end else begin
                    // A cycle with CYC low aborts everything in flight.
                    vld_p1 <= bus.CYC & vld_p0;
                end
            end

            always_ff @(posedge CLK) begin
                if (vld_p0) begin
                    we_p1   <= we_p0;
                    fail_p1 <= fail_p0;
                    adr_p1  <= adr_p0;
                    dat_p1  <= dat_p0;
                    tgd_p1  <= tgd_p0;
                end
            end

            assign src_vld  = vld_p1;
            assign src_we   = we_p1;
            assign src_fail = fail_p1;
            assign src_adr  = adr_p1;
            assign src_dat  = dat_p1;
            assign src_tgd  = tgd_p1;
        end
    end

    // ---- output stage: termination and read data -------------------------
    logic                 term;
    logic                 err_term;
    logic                 ack_q;
    logic                 err_q;
    logic [DataWidth-1:0] dat_q;
    logic [Lanes-1:0]     tgd_q;

    assign term     = bus.CYC & src_vld;
    assign err_term = term & src_fail;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            tgd_q <= '0;
        end else begin
            ack_q <= term & ~src_fail;
            err_q <= err_term;
            // Read data holds between read responses; writes leave it alone.
            if (term && !src_we) begin
                dat_q <= src_dat;
                tgd_q <= src_tgd;
            end
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.ERR   = err_q;
    assign bus.DAT_O = dat_q;
    assign bus.TGD_O = tgd_q;

    // An error landing together with ErrClear counts as the first new error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ErrCount <= '0;
            ErrAddr  <= '0;
        end else if (err_term) begin
            ErrCount <= ErrClear ? 8'd1 : sat_inc(ErrCount);
            ErrAddr  <= src_adr;
        end else if (ErrClear) begin
            ErrCount <= '0;
        end
    end

endmodule
